// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and the data memory port.
// Places store lanes, extracts and extends load lanes, runs the ack handshake.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [5:0]  op_q;
    logic [1:0]  lane_q;
    logic        is_load_q;
    logic        done_q;
    logic [31:0] load_data_q;
    logic        misaligned_q;
    logic        timeout_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_wmask_q;
    logic [31:0] mem_wdata_q;

    logic        op_ok_d;
    logic        is_load_d;
    logic        misal_d;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d;
    logic [7:0]  rbyte_d;
    logic [15:0] rhalf_d;
    logic [31:0] rdata_d;

    // Decode the incoming access: legality, alignment and store lane placement.
    always_comb begin
        op_ok_d   = 1'b1;
        is_load_d = 1'b0;
        misal_d   = 1'b0;
        wmask_d   = 4'b0000;
        wdata_d   = 32'b0;
        case (opcode)
            6'h20, 6'h24: begin
                is_load_d = 1'b1;
            end
            6'h21, 6'h25: begin
                is_load_d = 1'b1;
                misal_d   = addr[0];
            end
            6'h23: begin
                is_load_d = 1'b1;
                misal_d   = |addr[1:0];
            end
            6'h28: begin
                wmask_d = 4'b0001 << addr[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            6'h29: begin
                misal_d = addr[0];
                wmask_d = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{store_data[15:0]}};
            end
            6'h2b: begin
                misal_d = |addr[1:0];
                wmask_d = 4'b1111;
                wdata_d = store_data;
            end
            default: begin
                op_ok_d = 1'b0;
            end
        endcase
    end

    // Pick the addressed lane of the read word and extend it per load kind.
    always_comb begin
        rbyte_d = mem_rdata[7:0];
        case (lane_q)
            2'd1:    rbyte_d = mem_rdata[15:8];
            2'd2:    rbyte_d = mem_rdata[23:16];
            2'd3:    rbyte_d = mem_rdata[31:24];
            default: rbyte_d = mem_rdata[7:0];
        endcase
        rhalf_d = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            6'h20:   rdata_d = {{24{rbyte_d[7]}}, rbyte_d};
            6'h24:   rdata_d = {24'b0, rbyte_d};
            6'h21:   rdata_d = {{16{rhalf_d[15]}}, rhalf_d};
            6'h25:   rdata_d = {16'b0, rhalf_d};
            default: rdata_d = mem_rdata;
        endcase
    end

    // Access FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            op_q         <= 6'd0;
            lane_q       <= 2'd0;
            is_load_q    <= 1'b0;
            done_q       <= 1'b0;
            load_data_q  <= 32'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'b0;
            mem_wmask_q  <= 4'b0;
            mem_wdata_q  <= 32'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q        <= 8'd0;
                    misaligned_q <= 1'b0;
                    timeout_q    <= 1'b0;
                    if (start && op_ok_d) begin
                        if (misal_d) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q     <= S_REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= ~is_load_d;
                            mem_addr_q  <= {addr[31:2], 2'b00};
                            mem_wmask_q <= wmask_d;
                            mem_wdata_q <= wdata_d;
                            op_q        <= opcode;
                            lane_q      <= addr[1:0];
                            is_load_q   <= is_load_d;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mem_ack || cnt_q == LAST_CNT) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wmask_q <= 4'b0;
                        if (mem_ack) begin
                            if (is_load_q) begin
                                load_data_q <= rdata_d;
                            end
                        end else begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    cnt_q        <= 8'd0;
                    misaligned_q <= 1'b0;
                    timeout_q    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign load_data  = load_data_q;
    assign misaligned = misaligned_q;
    assign timeout    = timeout_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wmask  = mem_wmask_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and randomized accesses
// checked against an arithmetic model of lane placement and extension.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_load = 32'b0;

    logic [5:0] load_ops [5] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23};
    logic [5:0] store_ops [3] = '{6'h28, 6'h29, 6'h2b};

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opcode     (opcode),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned),
        .timeout    (timeout),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [31:0] model_size(input logic [5:0] op);
        if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 32'd1;
        if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 32'd2;
        return 32'd4;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (op)
            6'h20:   return (b >= 128) ? b - 32'd256 : b;
            6'h24:   return b;
            6'h21:   return (h >= 32768) ? h - 32'd65536 : h;
            6'h25:   return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_wmask(input logic [5:0] op,
                                               input logic [31:0] a);
        if (op == 6'h28) return 4'(32'd1 << (a % 4));
        if (op == 6'h29) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] op,
                                                input logic [31:0] d);
        if (op == 6'h28) return (d & 32'hFF) * 32'h0101_0101;
        if (op == 6'h29) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one access; ack_at = REQ cycle number carrying the ack (0 = never).
    task automatic run_access(input logic [5:0] op, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd,
                              input int ack_at,
                              output int req_n, output int first_req,
                              output int done_at,
                              output logic [31:0] o_addr,
                              output logic [31:0] o_wdata,
                              output logic [31:0] o_ld,
                              output logic [3:0] o_wmask,
                              output logic o_we, output logic o_mis,
                              output logic o_to, output logic o_busy_ok,
                              output logic o_stable, output logic o_clean);
        req_n = 0; first_req = 0; done_at = 0;
        o_addr = 0; o_wdata = 0; o_ld = 0; o_wmask = 0;
        o_we = 0; o_mis = 0; o_to = 0;
        o_busy_ok = 1; o_stable = 1; o_clean = 0;
        start = 1'b1;
        opcode = op;
        addr = a;
        store_data = sd;
        next_cycle();
        start = 1'b0;
        addr = $urandom;
        store_data = $urandom;
        for (int c = 1; c <= 40 && done_at == 0; c++) begin
            if (busy !== 1'b1) o_busy_ok = 0;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (mem_req === 1'b1) begin
                req_n++;
                if (req_n == 1) begin
                    first_req = c;
                    o_addr = mem_addr;
                    o_wdata = mem_wdata;
                    o_wmask = mem_wmask;
                    o_we = mem_we;
                end else if (mem_addr !== o_addr || mem_wdata !== o_wdata ||
                             mem_wmask !== o_wmask || mem_we !== o_we) begin
                    o_stable = 0;
                end
                if (req_n == ack_at) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end
            end
            if (done === 1'b1) begin
                done_at = c;
                o_ld = load_data;
                o_mis = misaligned;
                o_to = timeout;
            end
            next_cycle();
        end
        mem_ack = 1'b0;
        o_clean = (done === 0 && busy === 0 && misaligned === 0 &&
                   timeout === 0 && mem_req === 0);
    endtask

    int r_n, r_first, r_done;
    logic [31:0] r_addr, r_wdata, r_ld;
    logic [3:0] r_wmask;
    logic r_we, r_mis, r_to, r_busy, r_stable, r_clean;

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; opcode = 6'h0; addr = 0; store_data = 0;
        mem_ack = 1'b0; mem_rdata = 0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        n_checks++;
        if ({busy, done, misaligned, timeout, mem_req, mem_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 000000",
                     {busy, done, misaligned, timeout, mem_req, mem_we});
        end
        n_checks++;
        if ({load_data, mem_addr, mem_wdata, mem_wmask} !== 100'b0) begin
            n_fail++;
            $display("FAIL reset_data got %h %h %h %h exp zeros",
                     load_data, mem_addr, mem_wdata, mem_wmask);
        end
        last_load = 32'b0;
    endtask

    task automatic test_load_ext();
        logic [5:0] op;
        logic [31:0] a, rd, sz, exp;
        int k;
        run_access(6'h20, 32'h103, 0, 32'h80FF_1234, 1, r_n, r_first, r_done,
                   r_addr, r_wdata, r_ld, r_wmask, r_we, r_mis, r_to,
                   r_busy, r_stable, r_clean);
        n_checks++;
        if (r_ld !== 32'hFFFF_FF80 || r_addr !== 32'h100 || r_done != 2) begin
            n_fail++;
            $display("FAIL lb got %h addr %h done@%0d exp ffffff80 100 2",
                     r_ld, r_addr, r_done);
        end
        run_access(6'h24, 32'h103, 0, 32'h80FF_1234, 1, r_n, r_first, r_done,
                   r_addr, r_wdata, r_ld, r_wmask, r_we, r_mis, r_to,
                   r_busy, r_stable, r_clean);
        n_checks++;
        if (r_ld !== 32'h0000_0080 || r_we !== 1'b0 || r_wmask !== 4'h0) begin
            n_fail++;
            $display("FAIL lbu got %h we %b mask %h exp 00000080 0 0",
                     r_ld, r_we, r_wmask);
        end
        last_load = 32'h80;
        for (int i = 0; i < 24; i++) begin
            op = load_ops[$urandom_range(0, 4)];
            sz = model_size(op);
            a = $urandom;
            a = a - (a % sz);
            rd = $urandom;
            k = $urandom_range(1, 4);
            run_access(op, a, $urandom, rd, k, r_n, r_first, r_done,
                       r_addr, r_wdata, r_ld, r_wmask, r_we, r_mis, r_to,
                       r_busy, r_stable, r_clean);
            exp = model_load(op, a, rd);
            n_checks++;
            if (r_ld !== exp || r_addr !== (a - (a % 4)) || r_we !== 1'b0 ||
                r_wmask !== 4'h0 || r_mis !== 1'b0 || r_to !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_load op %h a %h got %h/%h exp %h/%h",
                         op, a, r_ld, r_addr, exp, a - (a % 4));
            end
            n_checks++;
            if (r_first != 1 || r_done != k + 1 || !r_busy ||
                !r_stable || !r_clean) begin
                n_fail++;
                $display("FAIL rand_load_timing req@%0d done@%0d k %0d %b%b%b",
                         r_first, r_done, k, r_busy, r_stable, r_clean);
            end
            last_load = exp;
        end
    endtask

    task automatic test_halfword();
        run_access(6'h21, 32'h202, 0, 32'h9ABC_0000, 3, r_n, r_first, r_done,
                   r_addr, r_wdata, r_ld, r_wmask, r_we, r_mis, r_to,
                   r_busy, r_stable, r_clean);
        n_checks++;
        if (r_ld !== 32'hFFFF_9ABC || r_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL lh got %h addr %h exp ffff9abc 200", r_ld, r_addr);
        end
        n_checks++;
        if (r_done != 4 || r_n != 3 || !r_busy || !r_clean) begin
            n_fail++;
            $display("FAIL lh_delay done@%0d reqs %0d busy %b exp 4 3 1",
                     r_done, r_n, r_busy);
        end
        run_access(6'h25, 32'h202, 0, 32'h9ABC_0000, 3, r_n, r_first, r_done,
                   r_addr, r_wdata, r_ld, r_wmask, r_we, r_mis, r_to,
                   r_busy, r_stable, r_clean);
        n_checks++;
        if (r_ld !== 32'h0000_9ABC || r_done != 4) begin
            n_fail++;
            $display("FAIL lhu got %h done@%0d exp 00009abc 4", r_ld, r_done);
        end
        last_load = 32'h9ABC;
    endtask

    task automatic test_stores();
        logic [5:0] op;
        logic [31:0] a, sd, sz;
        run_access(6'h28, 32'h1, 32'hA5, 0, 1, r_n, r_first, r_done,
                   r_addr, r_wdata, r_ld, r_wmask, r_we, r_mis, r_to,
                   r_busy, r_stable, r_clean);
        n_checks++;
        if (r_wmask !== 4'b0010 || r_wdata !== 32'hA5A5_A5A5 || r_we !== 1'b1 ||
            r_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL sb got %b %h we %b exp 0010 a5a5a5a5 1",
                     r_wmask, r_wdata, r_we);
        end
        run_access(6'h29, 32'h6, 32'h1234, 0, 2, r_n, r_first, r_done,
                   r_addr, r_wdata, r_ld, r_wmask, r_we, r_mis, r_to,
                   r_busy, r_stable, r_clean);
        n_checks++;
        if (r_wmask !== 4'b1100 || r_addr !== 32'h4 ||
            r_wdata !== 32'h1234_1234) begin
            n_fail++;
            $display("FAIL sh got %b %h %h exp 1100 4 12341234",
                     r_wmask, r_addr, r_wdata);
        end
        run_access(6'h2b, 32'h8, 32'hDEAD_BEEF, 0, 1, r_n, r_first, r_done,
                   r_addr, r_wdata, r_ld, r_wmask, r_we, r_mis, r_to,
                   r_busy, r_stable, r_clean);
        n_checks++;
        if (r_wmask !== 4'b1111 || r_wdata !== 32'hDEAD_BEEF ||
            r_ld !== last_load) begin
            n_fail++;
            $display("FAIL sw got %b %h ld %h exp 1111 deadbeef %h",
                     r_wmask, r_wdata, r_ld, last_load);
        end
        for (int i = 0; i < 16; i++) begin
            op = store_ops[$urandom_range(0, 2)];
            sz = model_size(op);
            a = $urandom;
            a = a - (a % sz);
            sd = $urandom;
            run_access(op, a, sd, $urandom, $urandom_range(1, 3),
                       r_n, r_first, r_done, r_addr, r_wdata, r_ld, r_wmask,
                       r_we, r_mis, r_to, r_busy, r_stable, r_clean);
            n_checks++;
            if (r_we !== 1'b1 || r_wmask !== model_wmask(op, a) ||
                r_wdata !== model_wdata(op, sd) ||
                r_addr !== (a - (a % 4)) || r_ld !== last_load ||
                !r_stable || !r_clean || r_done == 0) begin
                n_fail++;
                $display("FAIL rand_store op %h a %h got %b %h %h ld %h",
                         op, a, r_wmask, r_wdata, r_addr, r_ld);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [5:0] op;
        logic [31:0] a, sz;
        run_access(6'h23, 32'h102, 0, 0, 1, r_n, r_first, r_done,
                   r_addr, r_wdata, r_ld, r_wmask, r_we, r_mis, r_to,
                   r_busy, r_stable, r_clean);
        n_checks++;
        if (r_done != 1 || r_mis !== 1'b1 || r_to !== 1'b0 || r_n != 0 ||
            r_ld !== last_load || !r_clean) begin
            n_fail++;
            $display("FAIL mis_lw done@%0d mis %b reqs %0d ld %h",
                     r_done, r_mis, r_n, r_ld);
        end
        run_access(6'h29, 32'h3, 32'h55, 0, 1, r_n, r_first, r_done,
                   r_addr, r_wdata, r_ld, r_wmask, r_we, r_mis, r_to,
                   r_busy, r_stable, r_clean);
        n_checks++;
        if (r_done != 1 || r_mis !== 1'b1 || r_n != 0 || !r_clean) begin
            n_fail++;
            $display("FAIL mis_sh done@%0d mis %b reqs %0d", r_done, r_mis, r_n);
        end
        for (int i = 0; i < 8; i++) begin
            op = (i % 2 == 0) ? load_ops[$urandom_range(2, 4)]
                              : store_ops[$urandom_range(1, 2)];
            sz = model_size(op);
            a = $urandom;
            if (a % sz == 0) a = a + 1;
            run_access(op, a, $urandom, $urandom, 1, r_n, r_first, r_done,
                       r_addr, r_wdata, r_ld, r_wmask, r_we, r_mis, r_to,
                       r_busy, r_stable, r_clean);
            n_checks++;
            if (r_done != 1 || r_mis !== 1'b1 || r_n != 0 ||
                r_ld !== last_load) begin
                n_fail++;
                $display("FAIL rand_mis op %h a %h done@%0d mis %b reqs %0d",
                         op, a, r_done, r_mis, r_n);
            end
        end
    endtask

    task automatic test_timeout();
        run_access(6'h23, 32'h40, 0, 32'h1111_2222, 0, r_n, r_first, r_done,
                   r_addr, r_wdata, r_ld, r_wmask, r_we, r_mis, r_to,
                   r_busy, r_stable, r_clean);
        n_checks++;
        if (r_n != 16 || r_done != 17 || r_to !== 1'b1 || r_mis !== 1'b0 ||
            r_ld !== last_load || !r_clean) begin
            n_fail++;
            $display("FAIL timeout reqs %0d done@%0d to %b ld %h exp 16 17 1 %h",
                     r_n, r_done, r_to, r_ld, last_load);
        end
        run_access(6'h23, 32'h44, 0, 32'h3333_4444, 16, r_n, r_first, r_done,
                   r_addr, r_wdata, r_ld, r_wmask, r_we, r_mis, r_to,
                   r_busy, r_stable, r_clean);
        n_checks++;
        if (r_done != 17 || r_to !== 1'b0 || r_ld !== 32'h3333_4444) begin
            n_fail++;
            $display("FAIL ack_at_limit done@%0d to %b ld %h exp 17 0 33334444",
                     r_done, r_to, r_ld);
        end
        last_load = 32'h3333_4444;
    endtask

    task automatic test_reset_mid();
        int bad;
        start = 1'b1; opcode = 6'h23; addr = 32'h80;
        next_cycle();
        start = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, mem_req, mem_we, misaligned, timeout} !== 6'b0 ||
            {load_data, mem_addr, mem_wdata, mem_wmask} !== 100'b0) begin
            n_fail++;
            $display("FAIL reset_mid ctrl %b ld %h addr %h exp zeros",
                     {busy, done, mem_req, mem_we, misaligned, timeout},
                     load_data, mem_addr);
        end
        bad = 0;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 ||
                load_data !== 32'b0) bad++;
        end
        mem_ack = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stray_ack got %0d bad cycles exp 0", bad);
        end
        last_load = 32'b0;
    endtask

    task automatic test_start_busy();
        int ndone, done_at, req_n;
        logic addr_ok;
        ndone = 0; done_at = 0; req_n = 0; addr_ok = 1;
        start = 1'b1; opcode = 6'h2b; addr = 32'h10; store_data = 32'h77;
        next_cycle();
        for (int c = 1; c <= 8; c++) begin
            opcode = 6'h23;
            addr = 32'h102;
            start = busy;
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                req_n++;
                if (mem_addr !== 32'h10) addr_ok = 0;
                if (req_n == 3) mem_ack = 1'b1;
            end
            if (done === 1'b1) begin
                ndone++;
                done_at = c;
                if (misaligned !== 1'b0) addr_ok = 0;
            end
            next_cycle();
        end
        start = 1'b0;
        mem_ack = 1'b0;
        n_checks++;
        if (ndone != 1 || done_at != 4 || !addr_ok) begin
            n_fail++;
            $display("FAIL start_busy dones %0d done@%0d ok %b exp 1 4 1",
                     ndone, done_at, addr_ok);
        end
    endtask

    task automatic test_bad_opcode();
        int bad;
        bad = 0;
        start = 1'b1; opcode = 6'h0d; addr = 32'h0;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0) bad++;
            next_cycle();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bad_opcode got %0d active cycles exp 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_halfword();
        test_stores();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_start_busy();
        test_bad_opcode();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Sequential load/store unit between the MEM stage and the data memory port. It accepts one access per `start` and drives a request/acknowledge memory handshake. For stores it places bytes and halfwords into the correct byte lanes with write masks. For loads it extracts the addressed lane and sign- or zero-extends it according to the opcode. It sits downstream of the immediate extender and stalls the pipeline through `busy` until the access completes.

Parameters:
- TIMEOUT, 16, cycles in REQ without `mem_ack` before the access aborts (range 2..255).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle access request; sampled only in IDLE
- opcode  input  6  MIPS primary opcode of the access
- addr  input  32  effective byte address
- store_data  input  32  rt value for stores
- busy  output  1  high in every state other than IDLE
- done  output  1  one-cycle completion pulse
- load_data  output  32  extended load result; valid with `done`, held until the next `done`
- misaligned  output  1  valid with `done`: address-alignment error
- timeout  output  1  valid with `done`: memory did not acknowledge
- mem_req  output  1  memory request, held until acknowledged
- mem_we  output  1  1 = write
- mem_addr  output  32  word address, i.e. {addr[31:2], 2'b00}
- mem_wmask  output  4  byte-lane write enable; bit i corresponds to bits 8i+7:8i
- mem_wdata  output  32  lane-placed store data
- mem_ack  input  1  memory completion, sampled in REQ
- mem_rdata  input  32  read word, valid in the cycle `mem_ack` is high

Behaviour:
- Little-endian. Byte lane = addr[1:0]; halfword lane = addr[1].
- Supported opcodes:
  - loads: 0x20 lb (sign), 0x24 lbu (zero), 0x21 lh (sign), 0x25 lhu (zero), 0x23 lw
  - stores: 0x28 sb, 0x29 sh, 0x2b sw
  - `start` with any other opcode is ignored: stays IDLE, no `done`.
- Alignment: lh/lhu/sh require addr[0]=0; lw/sw require addr[1:0]=0; byte accesses are always aligned.
- Reset: state=IDLE. All outputs 0, including `load_data`, `mem_addr`, `mem_wdata` and `mem_wmask`. The timeout counter is cleared. Reset mid-access abandons the access: `mem_req` drops the next cycle and no `done` is produced.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On `start` with a supported opcode and misaligned address: go to DONE with misaligned=1, timeout=0, load_data unchanged. No memory request is issued.
  - On `start` with a supported opcode and aligned address: register mem_addr, mem_we, mem_wmask, mem_wdata and the access kind, then go to REQ.
- REQ:
  - `mem_req`=1. All `mem_*` outputs are stable until the state is left.
  - Counter increments each cycle.
  - If `mem_ack`=1: for loads, register `load_data` from `mem_rdata`. Go to DONE with misaligned=0, timeout=0.
  - Else if counter reaches TIMEOUT-1: go to DONE with timeout=1 and `load_data` unchanged.
  - `mem_ack` and the timeout in the same cycle: ack wins.
- DONE:
  - `done`=1 for exactly one cycle; `busy` is 1 in this cycle.
  - Return to IDLE; `mem_req`=0 and the counter is cleared.
  - misaligned and timeout return to 0 in IDLE.
- Latency:
  - Aligned access: start in cycle 0 → `mem_req` first high in cycle 1 → ack in cycle k (k≥1) → `done` in cycle k+1.
  - Misaligned access: `done` in cycle 1.
- `mem_ack` outside REQ is ignored. `start` while `busy` is ignored.
- Store lane placement:
  - sb: wmask = 4'b0001 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - sh: wmask = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{store_data[15:0]}}.
  - sw: wmask = 4'b1111; wdata = store_data.
- Loads: `mem_wmask` = 0 and `mem_we` = 0. The extracted lane is sign-extended (lb, lh) or zero-extended (lbu, lhu) to 32 bits; lw passes `mem_rdata` unchanged.

Test Plan:
- Load extension: lb at addr 0x103, mem_rdata 0x80FF_1234 → load_data 0xFFFF_FF80, mem_addr 0x100. lbu at the same address and data → 0x0000_0080.
- Halfword load: lh at addr 0x202, rdata 0x9ABC_0000 → 0xFFFF_9ABC. lhu at the same address and data → 0x0000_9ABC. Ack delayed 3 cycles → `done` 1 cycle after ack, `busy` high throughout.
- Stores:
  - sb at addr 0x1 with store_data 0x0000_00A5 → wmask 0010, wdata 0xA5A5_A5A5, mem_we 1.
  - sh at addr 0x6 with store_data 0x1234 → wmask 1100, mem_addr 0x4.
  - sw at addr 0x8 → wmask 1111.
- Misalignment: lw at addr 0x102 → `done` in cycle 1 with misaligned=1, `mem_req` never asserted. sh at addr 0x3 → same response.
- Timeout with TIMEOUT=16: no ack → exactly 16 REQ cycles, then `done` with timeout=1 and `load_data` unchanged. A second run with ack in the 16th cycle → normal completion, timeout=0.
- Reset and ignored inputs:
  - rst asserted in cycle 2 of REQ → next cycle IDLE with all outputs 0 and no `done`; a stray ack afterwards is ignored.
  - `start` while `busy` is ignored.
  - opcode 0x0d with `start` → no response.
